// File: rtl/a2bridge_bus_emulator.sv
// Apple II motherboard + A2Bridge mux stand-in: generates a2_7M/a2_phi1, replays queued bus cycles, captures card responses.
// Define A2EMU_RESET_GEN_EN to hold a2_reset_n_o low for RESET_CYCLES Apple cycles after reset.
module a2bridge_bus_emulator #(
    parameter int          HALF_7M_CLKS = 4,
    parameter int          PHI_HALF_7M  = 7,
    parameter logic [15:0] IDLE_ADDR    = 16'hFFFF,
    parameter int          RESET_CYCLES = 16
) (
    input  logic        clk_logic,
    input  logic        reset,
    input  logic [3:0]  dip_switches_n_i,
    input  logic        txn_valid_i,
    output logic        txn_ready_o,
    input  logic [15:0] txn_addr_i,
    input  logic [7:0]  txn_data_i,
    input  logic        txn_rw_n_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic        rsp_driven_o,
    output logic        contention_o,
    output logic        a2_phi1_o,
    output logic        a2_7M_o,
    output logic        a2_reset_n_o,
    input  logic [1:0]  a2_bridge_sel_i,
    input  logic        a2_bridge_bus_a_oe_i,
    input  logic        a2_bridge_bus_d_oe_i,
    input  logic        a2_bridge_rd_i,
    input  logic        a2_bridge_wr_i,
    input  logic [7:0]  a2_bridge_d_i,
    output logic [7:0]  a2_bridge_d_o,
    output logic        a2_bridge_d_oe_o
);

`ifdef A2EMU_RESET_GEN_EN
    localparam bit RESET_GEN_EN = 1'b1;
`else
    localparam bit RESET_GEN_EN = 1'b0;
`endif

    localparam int CLK_W  = (HALF_7M_CLKS > 1) ? $clog2(HALF_7M_CLKS) : 1;
    localparam int EDGE_W = (PHI_HALF_7M > 1) ? $clog2(PHI_HALF_7M) : 1;
    localparam int GEN_W  = $clog2(RESET_CYCLES + 1);
    localparam logic [CLK_W-1:0]  CLK_LAST  = CLK_W'(HALF_7M_CLKS - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(PHI_HALF_7M - 1);
    localparam logic [GEN_W-1:0]  GEN_LAST  = GEN_W'(RESET_CYCLES - 1);

    typedef enum logic {PH_PHI1, PH_PHI0} phase_t;

    phase_t            phase, phase_next;
    logic [CLK_W-1:0]  clk_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic              tick_7m, phi_edge, phi_rise;
    logic              gen_busy;
    logic [GEN_W-1:0]  gen_cnt;
    logic [15:0]       cur_addr;
    logic [7:0]        cur_data;
    logic              cur_rw_n;
    logic [7:0]        cap_data;
    logic              cap_driven, cap_hit;
    logic [7:0]        mux_byte;

    assign tick_7m   = (clk_cnt == CLK_LAST);
    assign phi_edge  = tick_7m && (edge_cnt == EDGE_LAST);
    assign phi_rise  = phi_edge && (phase == PH_PHI0);
    assign a2_phi1_o = (phase == PH_PHI1);

    // Combinational handshake so the offered txn is taken on the very edge phi1 rises.
    assign txn_ready_o = !reset && phi_rise && txn_valid_i && !gen_busy;

    assign cap_hit = cur_rw_n && (phase == PH_PHI0) && !a2_bridge_wr_i &&
                     !a2_bridge_bus_d_oe_i && (a2_bridge_sel_i == 2'b10);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        phase_next = phase;
        if (phi_edge)
            phase_next = (phase == PH_PHI1) ? PH_PHI0 : PH_PHI1;
    end

    always_comb begin
        mux_byte = 8'h00;
        case (a2_bridge_sel_i)
            2'b00: mux_byte = cur_addr[7:0];
            2'b01: mux_byte = cur_addr[15:8];
            2'b10: mux_byte = cur_data;
            2'b11: mux_byte = {dip_switches_n_i, 2'b11, 1'b1, cur_rw_n};
            default: mux_byte = 8'h00;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_logic) begin
        if (reset) begin
            phase    <= PH_PHI1;
            clk_cnt  <= '0;
            edge_cnt <= '0;
            a2_7M_o  <= 1'b0;
        end else begin
            phase   <= phase_next;
            clk_cnt <= tick_7m ? '0 : clk_cnt + 1'b1;
            if (tick_7m) begin
                a2_7M_o  <= !a2_7M_o;
                edge_cnt <= (edge_cnt == EDGE_LAST) ? '0 : edge_cnt + 1'b1;
            end
        end
    end

    // Power-on reset generator for the Apple side; folds away when the feature is disabled.
    always_ff @(posedge clk_logic) begin
        if (reset) begin
            gen_busy     <= RESET_GEN_EN;
            gen_cnt      <= '0;
            a2_reset_n_o <= 1'b1;
        end else if (gen_busy) begin
            a2_reset_n_o <= 1'b0;
            if (phi_rise) begin
                if (gen_cnt == GEN_LAST) begin
                    gen_busy     <= 1'b0;
                    a2_reset_n_o <= 1'b1;
                end else begin
                    gen_cnt <= gen_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_logic) begin
        if (reset) begin
            cur_addr         <= IDLE_ADDR;
            cur_data         <= 8'h00;
            cur_rw_n         <= 1'b1;
            cap_data         <= 8'hFF;
            cap_driven       <= 1'b0;
            rsp_valid_o      <= 1'b0;
            rsp_data_o       <= 8'hFF;
            rsp_driven_o     <= 1'b0;
            contention_o     <= 1'b0;
            a2_bridge_d_o    <= 8'h00;
            a2_bridge_d_oe_o <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            if (phi_rise) begin
                // A capture on the closing edge still belongs to the cycle being reported.
                if (cur_rw_n) begin
                    rsp_valid_o  <= 1'b1;
                    rsp_data_o   <= cap_hit ? a2_bridge_d_i : cap_data;
                    rsp_driven_o <= cap_hit || cap_driven;
                end
                cap_data   <= 8'hFF;
                cap_driven <= 1'b0;
                if (txn_ready_o) begin
                    cur_addr <= txn_addr_i;
                    cur_data <= txn_data_i;
                    cur_rw_n <= txn_rw_n_i;
                end else begin
                    cur_addr <= IDLE_ADDR;
                    cur_data <= 8'h00;
                    cur_rw_n <= 1'b1;
                end
            end else if (cap_hit) begin
                cap_data   <= a2_bridge_d_i;
                cap_driven <= 1'b1;
            end

            a2_bridge_d_o    <= mux_byte;
            a2_bridge_d_oe_o <= !a2_bridge_rd_i &&
                                ((a2_bridge_sel_i == 2'b10) ? (!a2_bridge_bus_d_oe_i && !cur_rw_n)
                                                            : !a2_bridge_bus_a_oe_i);
            if (!a2_bridge_wr_i && a2_bridge_d_oe_o)
                contention_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_a2bridge_bus_emulator.sv
// Self-checking bench for a2bridge_bus_emulator: a timeline model keyed on the clk count since reset
// predicts clocks, handshakes, bus bytes and responses; directed steps carry randomized payloads.
module tb_a2bridge_bus_emulator;

    localparam int          HALF_7M_CLKS = 4;
    localparam int          PHI_HALF_7M  = 7;
    localparam logic [15:0] IDLE_ADDR    = 16'hFFFF;
    localparam int          RESET_CYCLES = 16;
    localparam int          HALF_CLKS    = HALF_7M_CLKS * PHI_HALF_7M;
    localparam int          CYC          = 2 * HALF_CLKS;

    logic        clk_logic = 1'b0;
    logic        reset;
    logic [3:0]  dip;
    logic        txn_valid, txn_ready, txn_rw_n;
    logic [15:0] txn_addr;
    logic [7:0]  txn_data;
    logic        rsp_valid, rsp_driven, contention;
    logic [7:0]  rsp_data;
    logic        phi1, clk7m, a2_reset_n;
    logic [1:0]  sel;
    logic        a_oe_n, d_oe_n, rd_n, wr_n;
    logic [7:0]  d_i, d_o;
    logic        d_oe;

    int checks = 0;
    int errors = 0;
    int k      = 0;

    // Reference state: the bus cycle in progress and what has been published so far.
    logic [15:0] m_addr;
    logic [7:0]  m_data, m_cap, m_rsp_data, m_dout;
    logic        m_rw, m_drv, m_rsp_valid, m_rsp_drv, m_doe, m_cont;

    a2bridge_bus_emulator #(
        .HALF_7M_CLKS(HALF_7M_CLKS), .PHI_HALF_7M(PHI_HALF_7M),
        .IDLE_ADDR(IDLE_ADDR), .RESET_CYCLES(RESET_CYCLES)
    ) dut (
        .clk_logic(clk_logic), .reset(reset), .dip_switches_n_i(dip),
        .txn_valid_i(txn_valid), .txn_ready_o(txn_ready), .txn_addr_i(txn_addr),
        .txn_data_i(txn_data), .txn_rw_n_i(txn_rw_n),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_driven_o(rsp_driven),
        .contention_o(contention), .a2_phi1_o(phi1), .a2_7M_o(clk7m), .a2_reset_n_o(a2_reset_n),
        .a2_bridge_sel_i(sel), .a2_bridge_bus_a_oe_i(a_oe_n), .a2_bridge_bus_d_oe_i(d_oe_n),
        .a2_bridge_rd_i(rd_n), .a2_bridge_wr_i(wr_n), .a2_bridge_d_i(d_i),
        .a2_bridge_d_o(d_o), .a2_bridge_d_oe_o(d_oe)
    );

    always #5 clk_logic = ~clk_logic;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    // True when the phi1 rise after clk count kk may accept a transaction.
    function automatic bit gen_ok(input int kk);
`ifdef A2EMU_RESET_GEN_EN
        return ((kk + 1) / CYC) > RESET_CYCLES;
`else
        return kk >= 0;
`endif
    endfunction

    function automatic logic exp_reset_n(input int kk);
`ifdef A2EMU_RESET_GEN_EN
        return (reset || kk == 0 || kk >= RESET_CYCLES * CYC);
`else
        return kk >= 0;
`endif
    endfunction

    task automatic model_reset();
        m_addr = IDLE_ADDR; m_data = 8'h00; m_rw = 1'b1;
        m_cap = 8'hFF; m_drv = 1'b0;
        m_rsp_valid = 1'b0; m_rsp_data = 8'hFF; m_rsp_drv = 1'b0;
        m_dout = 8'h00; m_doe = 1'b0; m_cont = 1'b0;
    endtask

    // One clk: predict the edge from current inputs, step, then compare everything at the falling edge.
    task automatic cyc();
        bit          acc, ph0, rise;
        logic [7:0]  mux;
        logic        doe, cont;
        ph0  = ((k / HALF_CLKS) % 2) == 1;
        rise = (k % CYC) == CYC - 1;
        acc  = txn_valid && rise && gen_ok(k) && !reset;
        case (sel)
            2'b00:   mux = m_addr[7:0];
            2'b01:   mux = m_addr[15:8];
            2'b10:   mux = m_data;
            default: mux = {dip, 2'b11, 1'b1, m_rw};
        endcase
        doe  = !rd_n && ((sel == 2'b10) ? (!d_oe_n && !m_rw) : !a_oe_n);
        cont = m_cont || (!wr_n && m_doe);
        if (m_rw && ph0 && !wr_n && !d_oe_n && sel == 2'b10) begin
            m_cap = d_i;
            m_drv = 1'b1;
        end
        @(posedge clk_logic);
        if (reset) begin
            k = 0;
            model_reset();
        end else begin
            k++;
            m_rsp_valid = 1'b0;
            if (rise) begin
                m_rsp_valid = m_rw;
                if (m_rw) begin
                    m_rsp_data = m_cap;
                    m_rsp_drv  = m_drv;
                end
                m_cap = 8'hFF;
                m_drv = 1'b0;
                if (acc) begin
                    m_addr = txn_addr; m_data = txn_data; m_rw = txn_rw_n;
                end else begin
                    m_addr = IDLE_ADDR; m_data = 8'h00; m_rw = 1'b1;
                end
            end
            m_dout = mux;
            m_doe  = doe;
            m_cont = cont;
        end
        @(negedge clk_logic);
        check("phi1", phi1, ((k / HALF_CLKS) % 2) == 0);
        check("a2_7M", clk7m, ((k / HALF_7M_CLKS) % 2) == 1);
        check("reset_n", a2_reset_n, exp_reset_n(k));
        check("txn_ready", txn_ready, txn_valid && !reset && (k % CYC == CYC - 1) && gen_ok(k));
        check("rsp_valid", rsp_valid, m_rsp_valid);
        check("rsp_data", rsp_data, m_rsp_data);
        check("rsp_driven", rsp_driven, m_rsp_drv);
        check("d_oe", d_oe, m_doe);
        check("d_o", d_o, m_dout);
        check("contention", contention, m_cont);
    endtask

    task automatic goto(input int m);
        while (k % CYC != m) cyc();
    endtask

    task automatic bus_idle();
        sel = 2'b00; a_oe_n = 1'b1; d_oe_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic card_drive(input logic [7:0] b);
        sel = 2'b10; d_oe_n = 1'b0; wr_n = 1'b0; d_i = 8'($urandom);
        cyc();
        d_i = b;
        cyc();
        bus_idle();
    endtask

    task automatic release_reset();
        reset = 1'b0;
`ifdef A2EMU_RESET_GEN_EN
        txn_valid = 1'b1; txn_rw_n = 1'b0;
        while (k != RESET_CYCLES * CYC + CYC - 1) cyc();
        txn_valid = 1'b0;
`else
        goto(CYC - 1);
`endif
    endtask

    // Entered just before a phi1 rise. card: 0 silent, 1 drives in PHI0 (last byte b wins), 2 drives only in PHI1.
    task automatic apple_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw,
                               input bit valid, input int card, input logic [7:0] b);
        txn_valid = valid; txn_addr = a; txn_data = d; txn_rw_n = rw;
        cyc();
        txn_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = s[1:0]; rd_n = 1'b0; a_oe_n = 1'b0; d_oe_n = 1'b0;
            cyc();
        end
        bus_idle();
        cyc();
        if (card == 2) card_drive(b);
        goto(HALF_CLKS + 2);
        if (card == 1) card_drive(b);
        goto(CYC - 1);
    endtask

    initial begin
        reset = 1'b1; bus_idle(); d_i = 8'h00; dip = 4'($urandom);
        txn_valid = 1'b1; txn_addr = 16'h1234; txn_data = 8'h56; txn_rw_n = 1'b0;
        model_reset();
        repeat (3) cyc();
        release_reset();

        apple_cycle(16'hC0F4, 8'h00, 1'b1, 1'b1, 1, 8'h5A);
        apple_cycle(16'($urandom), 8'($urandom), 1'b1, 1'b1, 2, 8'($urandom));
        apple_cycle(16'hC0B0, 8'h3C, 1'b0, 1'b1, 1, 8'($urandom));
        apple_cycle(16'h0000, 8'h00, 1'b1, 1'b0, 1, 8'($urandom));
        for (int i = 0; i < 6; i++)
            apple_cycle(16'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
                        int'($urandom_range(0, 2)), 8'($urandom));

        // Valid held across two Apple cycles: one acceptance per phi1 rise.
        txn_valid = 1'b1; txn_addr = 16'($urandom); txn_data = 8'($urandom); txn_rw_n = 1'b0;
        repeat (2 * CYC) cyc();
        txn_valid = 1'b0;

        // Card drives while the emulator is driving the address byte.
        txn_valid = 1'b1; txn_addr = 16'($urandom); txn_rw_n = 1'b1;
        cyc();
        txn_valid = 1'b0;
        sel = 2'b00; a_oe_n = 1'b0; rd_n = 1'b0;
        cyc();
        wr_n = 1'b0;
        cyc();
        bus_idle();
        cyc();
        check("contention_set", contention, 1'b1);
        goto(CYC - 1);
        apple_cycle(16'($urandom), 8'($urandom), 1'b1, 1'b1, 1, 8'($urandom));
        check("contention_sticky", contention, 1'b1);

        // Reset in the middle of PHI0 of a read that already captured a byte.
        txn_valid = 1'b1; txn_addr = 16'($urandom); txn_rw_n = 1'b1;
        cyc();
        txn_valid = 1'b0;
        goto(HALF_CLKS + 2);
        card_drive(8'($urandom));
        goto(HALF_CLKS + 15);
        reset = 1'b1;
        cyc();
        check("reset_contention", contention, 1'b0);
        check("reset_rsp_data", rsp_data, 8'hFF);
        cyc();
        release_reset();
        apple_cycle(16'($urandom), 8'($urandom), 1'b1, 1'b1, 0, 8'h00);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
